// File: rtl/llr_pair_scaler.sv
// rtl/llr_pair_scaler.sv - scales a strobed RE pair by a noise factor into four saturated soft values
// One shared multiplier walks the four samples over four CALC cycles; one packed word per strobe.
module llr_pair_scaler #(
    parameter int LLR_W = 8,
    parameter int SHIFT = 12
) (
    input  logic        i_core_clk,
    input  logic        i_rx_rstn,
    input  logic        i_start,
    input  logic [15:0] i_cur_user_re_amounts,
    input  logic        i_data_strobe,
    input  logic [15:0] i_re0_data_i,
    input  logic [15:0] i_re0_data_q,
    input  logic [15:0] i_re1_data_i,
    input  logic [15:0] i_re1_data_q,
    input  logic [15:0] i_noise_data,
    output logic        o_llr_valid,
    output logic [31:0] o_llr_data,
    output logic        o_llr_last,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic signed [33:0] ROUND  = 34'sd1 <<< (SHIFT - 1);
    localparam logic signed [33:0] SAT_HI = (34'sd1 <<< (LLR_W - 1)) - 34'sd1;
    localparam logic signed [33:0] SAT_LO = -SAT_HI;

    logic [1:0]             state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [15:0]            amounts_q, amounts_d;
    logic [16:0]            re_cnt_q, re_cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   started_q, started_d;
    logic                   zero_done_q, zero_done_d;
    logic [3:0][15:0]       smp_q, smp_d;
    logic [15:0]            noise_q, noise_d;
    logic [2:0][LLR_W-1:0]  part_q, part_d;
    logic [31:0]            data_q, data_d;

    logic                   latch;
    logic                   last_word;
    logic                   odd_tail;
    logic signed [15:0]     smp_sel;
    logic signed [32:0]     prod;
    logic signed [33:0]     biased;
    logic signed [33:0]     shifted;
    logic [LLR_W-1:0]       sat_val;
    logic [LLR_W-1:0]       llr_val;

    assign last_word = (re_cnt_q + 17'd2) >= {1'b0, amounts_q};
    assign odd_tail  = (re_cnt_q + 17'd1) == {1'b0, amounts_q};

    // Noise is unsigned, so it enters the signed multiply with a zero sign bit.
    assign smp_sel = $signed(smp_q[idx_q]);
    assign prod    = smp_sel * $signed({1'b0, noise_q});
    assign biased  = {prod[32], prod} + ROUND;
    assign shifted = biased >>> SHIFT;

    always_comb begin
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[LLR_W-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[LLR_W-1:0];
        end else begin
            sat_val = shifted[LLR_W-1:0];
        end
    end

    // An odd allocation ends on a half-filled pair: the RE1 lanes of that word are blanked.
    assign llr_val = (odd_tail && idx_q[1]) ? '0 : sat_val;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        amounts_d   = amounts_q;
        re_cnt_d    = re_cnt_q;
        overrun_d   = overrun_q;
        started_d   = started_q;
        zero_done_d = 1'b0;
        smp_d       = smp_q;
        noise_d     = noise_q;
        part_d      = part_q;
        data_d      = data_q;
        latch       = 1'b0;

        if (i_start) begin
            amounts_d = i_cur_user_re_amounts;
            re_cnt_d  = '0;
            overrun_d = 1'b0;
            started_d = 1'b1;
            idx_d     = '0;
            if (i_cur_user_re_amounts == 16'd0) begin
                state_d     = S_IDLE;
                zero_done_d = 1'b1;
            end else begin
                state_d = S_WAIT;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_data_strobe && started_q) begin
                        overrun_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    latch = i_data_strobe;
                end
                S_CALC: begin
                    if (i_data_strobe) begin
                        overrun_d = 1'b1;
                    end
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: part_d[0] = llr_val;
                        2'd1: part_d[1] = llr_val;
                        2'd2: part_d[2] = llr_val;
                        default: begin
                            data_d  = {llr_val, part_q[2], part_q[1], part_q[0]};
                            state_d = S_OUT;
                        end
                    endcase
                end
                default: begin
                    re_cnt_d = re_cnt_q + 17'd2;
                    if (last_word) begin
                        state_d = S_IDLE;
                    end else if (i_data_strobe) begin
                        latch = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            endcase

            if (latch) begin
                smp_d   = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};
                noise_d = i_noise_data;
                idx_d   = '0;
                state_d = S_CALC;
            end
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            amounts_q   <= '0;
            re_cnt_q    <= '0;
            overrun_q   <= 1'b0;
            started_q   <= 1'b0;
            zero_done_q <= 1'b0;
            smp_q       <= '0;
            noise_q     <= '0;
            part_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            amounts_q   <= amounts_d;
            re_cnt_q    <= re_cnt_d;
            overrun_q   <= overrun_d;
            started_q   <= started_d;
            zero_done_q <= zero_done_d;
            smp_q       <= smp_d;
            noise_q     <= noise_d;
            part_q      <= part_d;
            data_q      <= data_d;
        end
    end

    // A start arriving in OUT aborts the word in the same cycle, hence the combinational gate.
    assign o_llr_valid = (state_q == S_OUT) && !i_start;
    assign o_llr_last  = o_llr_valid && last_word;
    assign o_done      = o_llr_last || zero_done_q;
    assign o_busy      = state_q != S_IDLE;
    assign o_overrun   = overrun_q;
    assign o_llr_data  = data_q;

endmodule
